fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Multi-cycle issue and writeback controller for the floating-point ALU. It accepts one COP1 arithmetic instruction at a time from decode, decodes format and function, and latches the operands. It then holds the ALU inputs stable for a per-operation latency, stalls the core while the ALU works, and writes the result to the FP register file. The block sits between decode, the FP register file and `F_alu`, and turns the combinational ALU into a sequenced, fixed-latency resource.

## Interface
- `ADD_LAT`, 2: cycles the ALU inputs are held for add/sub (≥1).
- `MUL_LAT`, 4: cycles held for mul (≥1).
- `DIV_LAT`, 12: cycles held for single-precision div; double-precision div uses 2*`DIV_LAT`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `issue_valid` in 1: decode presents an FP instruction; held until accepted.
- `cop` in 5: format field; 5'b10000 = single (S), 5'b10001 = double (D).
- `func` in 6: function field.
- `fd` in 5: destination FP register.
- `read_f_data1`, `read_f_data2` in 64: source operands.
- `flush` in 1: synchronous; drops any in-flight operation.
- `issue_ready` out 1: controller can accept an instruction.
- `stall` out 1: freezes PC and decode.
- `alu_cop` out 5, `alu_func` out 6, `alu_a` out 64, `alu_b` out 64: registered drive to `F_alu`.
- `alu_float_result` in 64: `F_alu` output.
- `f_wr_en` out 1, `f_wr_addr` out 5, `f_wr_data` out 64: FP register-file write port.
- `illegal_op` out 1: one-cycle pulse on an undecodable instruction.

## Operation
- Legal instructions are: `cop` ∈ {S, D} and `func` ∈ {000000 add, 000001 sub, 000010 mul, 000011 div, 000101 abs, 000110 mov, 000111 neg}. Any other combination is illegal.
- Latency per operation: add/sub use `ADD_LAT`; mul uses `MUL_LAT`; div uses `DIV_LAT` for S and 2*`DIV_LAT` for D; abs/mov/neg use 1.
- The FSM has three states: IDLE, EXEC and WB.
- **IDLE**
  - `issue_ready`=1.
  - Legal `issue_valid`: latch `cop`/`func`/`fd`/operands into the ALU drive registers, load `cnt`=lat-1, and go to EXEC.
  - Illegal `issue_valid`: pulse `illegal_op` for one cycle, issue no write, stay in IDLE. The core treats the instruction as retired.
- **EXEC**
  - ALU drive registers are held constant.
  - While `cnt`≠0, decrement `cnt`.
  - At `cnt`==0, capture `alu_float_result` into the result register and go to WB.
- **WB**
  - Assert `f_wr_en` for one cycle with `f_wr_addr`=latched `fd`.
  - `f_wr_data` = result for D, or {result[63:32], 32'h0} for S (single values live in the upper word).
  - Return to IDLE. `issue_ready`=0 in WB, so the still-present `issue_valid` is not re-accepted.
- `stall` = (IDLE & `issue_valid` & legal) | EXEC. `stall` is 0 in WB, so the core advances at the WB edge.
- `flush` has priority over all transitions: from any state, go to IDLE, with no `f_wr_en` that cycle or after, and `illegal_op` suppressed.
- `cnt` width is clog2(2*`DIV_LAT`); it never wraps, because it is reloaded only in IDLE.

## Timing
- Reset (asynchronous, active-high) forces:
  - state=IDLE, `cnt`=0.
  - `alu_*` = 0, `f_wr_en`=0, `f_wr_addr`=0, `f_wr_data`=0, `illegal_op`=0.
  - `issue_ready`=1 after reset deasserts; `stall`=0 when `issue_valid`=0.
- Accept at edge E0. EXEC occupies cycles 1..lat after E0, and WB is cycle lat+1.
- `f_wr_en` is high in cycle lat+1, so issue-to-writeback is lat+1 cycles. The next accept can occur at cycle lat+2.
- `alu_*` change only on the accept edge; they are stable throughout EXEC.
- Reset or flush mid-EXEC discards the operation, and the register file is untouched.

## Structure
- `fpu_pkg` holds:
  - `COP_S`, `COP_D` constants.
  - `FN_ADD`/`FN_SUB`/`FN_MUL`/`FN_DIV`/`FN_ABS`/`FN_MOV`/`FN_NEG` constants.
  - The state enum `{IDLE, EXEC, WB}`.
- One combinational sub-module, `fpu_op_decode`: (`cop`, `func`, parameters) → `legal`, `lat`. It is shared by this block and future FP hazard logic.

## Test plan
- Reset mid-EXEC of D div (24-cycle latency), asserted at cycle 10 → state IDLE, all outputs 0, no `f_wr_en` ever.
- S add, `fd`=3, a=0x3F800000_00000000, b=0x40000000_00000000, ALU model returns 0x40400000_xxxxxxxx → `stall` high for cycles 0..2, `f_wr_en` high in cycle 3, `f_wr_data`=0x40400000_00000000, `f_wr_addr`=3.
- D div with `DIV_LAT`=12 → `alu_*` constant for 24 cycles, single `f_wr_en` at cycle 25, `issue_ready` back at cycle 26.
- `cop`=5'b10000, `func`=6'b111111 → one-cycle `illegal_op`, `stall`=0, no write, `issue_ready` stays 1.
- Back-to-back: S mov then D mul with `issue_valid` held → mov writes at cycle 2, mul accepted at cycle 3, mul writes at cycle 3+`MUL_LAT`+1; each instruction written exactly once.
- `flush` asserted in the cycle before WB of a mul → no write, IDLE next cycle, new add accepted immediately.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP issue/writeback controller and
// other FP decode logic.
package fpu_pkg;

  localparam logic [4:0] COP_S = 5'b10000;
  localparam logic [4:0] COP_D = 5'b10001;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_MUL = 6'b000010;
  localparam logic [5:0] FN_DIV = 6'b000011;
  localparam logic [5:0] FN_ABS = 6'b000101;
  localparam logic [5:0] FN_MOV = 6'b000110;
  localparam logic [5:0] FN_NEG = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } fpu_state_e;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational COP1 arithmetic decode: legality and ALU hold latency.
module fpu_op_decode
  import fpu_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12,
  parameter int LAT_W   = $clog2(2*DIV_LAT) + 1
) (
  input  logic [4:0]       cop,
  input  logic [5:0]       func,
  output logic             legal,
  output logic [LAT_W-1:0] lat
);

  logic fmt_ok;

  always_comb begin
    fmt_ok = (cop == COP_S) || (cop == COP_D);
    legal  = 1'b0;
    lat    = LAT_W'(1);
    case (func)
      FN_ADD, FN_SUB: begin
        legal = fmt_ok;
        lat   = LAT_W'(ADD_LAT);
      end
      FN_MUL: begin
        legal = fmt_ok;
        lat   = LAT_W'(MUL_LAT);
      end
      FN_DIV: begin
        legal = fmt_ok;
        lat   = (cop == COP_D) ? LAT_W'(2*DIV_LAT) : LAT_W'(DIV_LAT);
      end
      FN_ABS, FN_MOV, FN_NEG: begin
        legal = fmt_ok;
        lat   = LAT_W'(1);
      end
      default: begin
        legal = 1'b0;
        lat   = LAT_W'(1);
      end
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences one FP ALU operation at a time: latch operands, hold them for the
// op latency while stalling the core, then write the result back.
//
// state | meaning
// IDLE  | ready; accepts a legal instruction, flags an illegal one
// EXEC  | ALU inputs held, cnt counts down the op latency
// WB    | one-cycle register-file write of the captured result
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  cop,
  input  logic [5:0]  func,
  input  logic [4:0]  fd,
  input  logic [63:0] read_f_data1,
  input  logic [63:0] read_f_data2,
  input  logic        flush,
  output logic        issue_ready,
  output logic        stall,
  output logic [4:0]  alu_cop,
  output logic [5:0]  alu_func,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_float_result,
  output logic        f_wr_en,
  output logic [4:0]  f_wr_addr,
  output logic [63:0] f_wr_data,
  output logic        illegal_op
);

  localparam int CNT_W = $clog2(2*DIV_LAT);
  localparam int LAT_W = CNT_W + 1;

  fpu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       fd_q;
  logic [63:0]      result_q;
  logic             legal;
  logic [LAT_W-1:0] lat;
  logic             accept;

  fpu_op_decode #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .LAT_W   (LAT_W)
  ) u_op_decode (
    .cop   (cop),
    .func  (func),
    .legal (legal),
    .lat   (lat)
  );

  assign accept = (state == IDLE) && issue_valid && legal && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (issue_valid && legal) state_nxt = EXEC;
        EXEC:    if (cnt == '0) state_nxt = WB;
        WB:      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      alu_cop  <= '0;
      alu_func <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      fd_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt      <= CNT_W'(lat - LAT_W'(1));
      alu_cop  <= cop;
      alu_func <= func;
      alu_a    <= read_f_data1;
      alu_b    <= read_f_data2;
      fd_q     <= fd;
    end else if (state == EXEC && !flush) begin
      if (cnt != '0) cnt      <= cnt - CNT_W'(1);
      else           result_q <= alu_float_result;
    end
  end

  // Single-precision results live in the upper word; the lower word is zeroed.
  always_comb begin
    issue_ready = (state == IDLE);
    stall       = ((state == IDLE) && issue_valid && legal) || (state == EXEC);
    f_wr_en     = (state == WB) && !flush;
    illegal_op  = (state == IDLE) && issue_valid && !legal && !flush;
    f_wr_addr   = fd_q;
    f_wr_data   = (alu_cop == COP_D) ? result_q : {result_q[63:32], 32'h0};
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: latency, writeback format, illegal ops,
// back-to-back issue, flush and reset.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  cop;
  logic [5:0]  func;
  logic [4:0]  fd;
  logic [63:0] read_f_data1, read_f_data2;
  logic        flush;
  logic        issue_ready, stall;
  logic [4:0]  alu_cop;
  logic [5:0]  alu_func;
  logic [63:0] alu_a, alu_b;
  logic [63:0] alu_res;
  logic        f_wr_en;
  logic [4:0]  f_wr_addr;
  logic [63:0] f_wr_data;
  logic        illegal_op;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int exp_wr = 0;

  fpu_issue_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .cop              (cop),
    .func             (func),
    .fd               (fd),
    .read_f_data1     (read_f_data1),
    .read_f_data2     (read_f_data2),
    .flush            (flush),
    .issue_ready      (issue_ready),
    .stall            (stall),
    .alu_cop          (alu_cop),
    .alu_func         (alu_func),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_float_result (alu_res),
    .f_wr_en          (f_wr_en),
    .f_wr_addr        (f_wr_addr),
    .f_wr_data        (f_wr_data),
    .illegal_op       (illegal_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (f_wr_en) wr_count <= wr_count + 1;

  // Presents one legal op, checks every cycle through WB; leaves issue_valid high.
  task automatic run_op(input string name, input logic [4:0] c, input logic [5:0] fn,
                        input logic [4:0] d, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input int lat);
    logic [63:0] exp_data;
    exp_data = (c == COP_D) ? res : {res[63:32], 32'h0};
    @(negedge clk);
    issue_valid = 1'b1; cop = c; func = fn; fd = d;
    read_f_data1 = a; read_f_data2 = b; flush = 1'b0; alu_res = ~res;
    #1;
    tests++;
    if (stall !== 1'b1 || issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: stall=%b ready=%b expected 1 1", name, stall, issue_ready);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      read_f_data1 = ~a; read_f_data2 = ~b; fd = ~d;
      alu_res = (k == lat) ? res : ~res;
      #1;
      tests++;
      if (stall !== 1'b1 || issue_ready !== 1'b0 || f_wr_en !== 1'b0) begin
        fails++;
        $display("FAIL %s exec c%0d: stall=%b ready=%b wr=%b expected 1 0 0",
                 name, k, stall, issue_ready, f_wr_en);
      end
      tests++;
      if (alu_cop !== c || alu_func !== fn || alu_a !== a || alu_b !== b) begin
        fails++;
        $display("FAIL %s alu_hold c%0d: cop=%h func=%h a=%h b=%h expected %h %h %h %h",
                 name, k, alu_cop, alu_func, alu_a, alu_b, c, fn, a, b);
      end
    end
    @(negedge clk);
    alu_res = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    tests++;
    if (f_wr_en !== 1'b1 || stall !== 1'b0 || issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s wb_ctrl: wr=%b stall=%b ready=%b expected 1 0 0",
               name, f_wr_en, stall, issue_ready);
    end
    tests++;
    if (f_wr_addr !== d || f_wr_data !== exp_data) begin
      fails++;
      $display("FAIL %s wb_data: addr=%0d data=%h expected %0d %h",
               name, f_wr_addr, f_wr_data, d, exp_data);
    end
    exp_wr++;
  endtask

  task automatic finish_idle(input string name);
    @(negedge clk);
    issue_valid = 1'b0; flush = 1'b0;
    #1;
    tests++;
    if (issue_ready !== 1'b1 || f_wr_en !== 1'b0 || stall !== 1'b0 || wr_count != exp_wr) begin
      fails++;
      $display("FAIL %s idle: ready=%b wr=%b stall=%b writes=%0d expected 1 0 0 %0d",
               name, issue_ready, f_wr_en, stall, wr_count, exp_wr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; cop = '0; func = '0; fd = '0;
    read_f_data1 = '0; read_f_data2 = '0; flush = 1'b0; alu_res = '0;
    #1;
    tests++;
    if (issue_ready !== 1'b1 || stall !== 1'b0 || f_wr_en !== 1'b0 || illegal_op !== 1'b0 ||
        alu_a !== 64'h0 || alu_b !== 64'h0 || alu_cop !== 5'h0 || alu_func !== 6'h0 ||
        f_wr_addr !== 5'h0 || f_wr_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b stall=%b wr=%b ill=%b a=%h data=%h expected 1 0 0 0 0 0",
               issue_ready, stall, f_wr_en, illegal_op, alu_a, f_wr_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_s();
    run_op("add_s", COP_S, FN_ADD, 5'd3, 64'h3F800000_00000000, 64'h40000000_00000000,
           64'h40400000_12345678, ADD_LAT);
    finish_idle("add_s");
  endtask

  task automatic test_div_d();
    run_op("div_d", COP_D, FN_DIV, 5'd17, 64'h40240000_00000000, 64'h40040000_00000000,
           64'h40100000_00000001, 2*DIV_LAT);
    finish_idle("div_d");
    run_op("div_s", COP_S, FN_DIV, 5'd9, 64'h41200000_00000000, 64'h40000000_00000000,
           64'h40A00000_FFFFFFFF, DIV_LAT);
    finish_idle("div_s");
  endtask

  task automatic test_misc_ops();
    run_op("mul_d", COP_D, FN_MUL, 5'd31, 64'h1, 64'h2, 64'hC000_0000_0000_0003, MUL_LAT);
    finish_idle("mul_d");
    run_op("sub_d", COP_D, FN_SUB, 5'd0, 64'h5, 64'h6, 64'h0123_4567_89AB_CDEF, ADD_LAT);
    finish_idle("sub_d");
    run_op("abs_s", COP_S, FN_ABS, 5'd5, 64'hBF800000_00000000, 64'h0,
           64'h3F800000_AAAAAAAA, 1);
    finish_idle("abs_s");
    run_op("neg_d", COP_D, FN_NEG, 5'd12, 64'h3FF00000_00000000, 64'h0,
           64'hBFF00000_00000000, 1);
    finish_idle("neg_d");
  endtask

  task automatic check_illegal(input string name, input logic [4:0] c, input logic [5:0] fn);
    @(negedge clk);
    issue_valid = 1'b1; cop = c; func = fn; fd = 5'd7; flush = 1'b0;
    #1;
    tests++;
    if (illegal_op !== 1'b1 || stall !== 1'b0 || issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s pulse: ill=%b stall=%b ready=%b expected 1 0 1",
               name, illegal_op, stall, issue_ready);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    tests++;
    if (illegal_op !== 1'b0 || issue_ready !== 1'b1 || wr_count != exp_wr) begin
      fails++;
      $display("FAIL %s after: ill=%b ready=%b writes=%0d expected 0 1 %0d",
               name, illegal_op, issue_ready, wr_count, exp_wr);
    end
  endtask

  task automatic test_illegal();
    check_illegal("ill_func", COP_S, 6'b111111);
    check_illegal("ill_fn4", COP_D, 6'b000100);
    check_illegal("ill_cop", 5'b10100, FN_ADD);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mov", COP_S, FN_MOV, 5'd4, 64'h3F800000_11111111, 64'h0,
           64'h3F800000_22222222, 1);
    run_op("b2b_mul", COP_D, FN_MUL, 5'd6, 64'h4000000000000000, 64'h4008000000000000,
           64'h4018000000000000, MUL_LAT);
    finish_idle("b2b");
  endtask

  task automatic test_flush();
    @(negedge clk);
    issue_valid = 1'b1; cop = COP_D; func = FN_MUL; fd = 5'd20;
    read_f_data1 = 64'hA; read_f_data2 = 64'hB; alu_res = 64'h1111;
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clk);
      if (k == MUL_LAT) flush = 1'b1;
      #1;
    end
    tests++;
    if (f_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_exec: wr=%b expected 0", f_wr_en);
    end
    run_op("flush_add", COP_S, FN_ADD, 5'd21, 64'h3F800000_00000000, 64'h3F800000_00000000,
           64'h40000000_55555555, ADD_LAT);
    finish_idle("flush_add");
    // Flush landing on the WB cycle itself must also suppress the write.
    @(negedge clk);
    issue_valid = 1'b1; cop = COP_S; func = FN_ABS; fd = 5'd22; alu_res = 64'h7;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    tests++;
    if (f_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_wb: wr=%b expected 0", f_wr_en);
    end
    @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1; cop = COP_S; func = 6'b111111;
    #1;
    tests++;
    if (illegal_op !== 1'b0) begin
      fails++;
      $display("FAIL flush_illegal: ill=%b expected 0", illegal_op);
    end
    finish_idle("flush_wb");
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    issue_valid = 1'b1; cop = COP_D; func = FN_DIV; fd = 5'd8;
    read_f_data1 = 64'h1234; read_f_data2 = 64'h5678; alu_res = 64'h9999;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    reset = 1'b1; issue_valid = 1'b0;
    #1;
    tests++;
    if (issue_ready !== 1'b1 || stall !== 1'b0 || f_wr_en !== 1'b0 || illegal_op !== 1'b0 ||
        alu_a !== 64'h0 || alu_b !== 64'h0 || alu_cop !== 5'h0 || alu_func !== 6'h0 ||
        f_wr_addr !== 5'h0 || f_wr_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid: ready=%b stall=%b wr=%b a=%h cop=%h addr=%0d expected 1 0 0 0 0 0",
               issue_ready, stall, f_wr_en, alu_a, alu_cop, f_wr_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) @(negedge clk);
    #1;
    tests++;
    if (wr_count != exp_wr || issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_write: writes=%0d ready=%b expected %0d 1",
               wr_count, issue_ready, exp_wr);
    end
  endtask

  initial begin
    test_reset();
    test_add_s();
    test_div_d();
    test_misc_ops();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
